// File: rtl/gb_mem_pkg.sv
// Shared types for the Game Boy memory blocks: FSM state encoding and depth helper.
package gb_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } iram_state_e;

  function automatic int unsigned iram_depth(input int unsigned addr_bits,
                                             input int unsigned bank_bits);
    return 32'd1 << (addr_bits + bank_bits);
  endfunction

endpackage

// File: rtl/banked_iram_array.sv
// Plain single-port synchronous RAM with registered read data.
// BANKED_IRAM_WRITE_THROUGH_EN selects write-first read data; default is read-first.
module banked_iram_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DEPTH      = 1 << 14
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
`ifdef BANKED_IRAM_WRITE_THROUGH_EN
    rdata_q <= we ? wdata : mem[addr];
`else
    rdata_q <= mem[addr];
`endif
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_iram.sv
// Banked work RAM with a clear sequencer that fills every word with CLEAR_VALUE
// after reset or on clear_req. Optional macro: BANKED_IRAM_WRITE_THROUGH_EN.
module banked_iram
  import gb_mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH  = 13,
  parameter int unsigned           BANK_WIDTH  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BANK_WIDTH-1:0] bank,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  busy
);

  localparam int unsigned PW    = ADDR_WIDTH + BANK_WIDTH;
  localparam int unsigned DEPTH = iram_depth(ADDR_WIDTH, BANK_WIDTH);

  iram_state_e           state_q, state_d;
  logic [PW-1:0]         clr_ptr_q, clr_ptr_d;
  logic                  busy_q;
  logic                  rd_sel_q;
  logic                  zero_q;
  logic                  ptr_last;

  logic [PW-1:0]         arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  arr_we;

  assign ptr_last = (clr_ptr_q == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      rd_sel_q  <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= (state_d == CLEAR);
      rd_sel_q  <= (state_q == IDLE);
      zero_q    <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + PW'(1);
        if (ptr_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // A pending clear request outranks a same-cycle write; reset blocks all writes.
  always_comb begin
    arr_addr  = {bank, address};
    arr_wdata = data;
    arr_we    = 1'b0;
    case (state_q)
      IDLE: begin
        arr_we = wren && !clear_req && !reset;
      end
      CLEAR: begin
        arr_addr  = clr_ptr_q;
        arr_wdata = CLEAR_VALUE;
        arr_we    = !reset;
      end
      default: arr_we = 1'b0;
    endcase
  end

  banked_iram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(PW),
    .DEPTH     (DEPTH)
  ) u_array (
    .clock(clock),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .we   (arr_we),
    .rdata(arr_rdata)
  );

  // Array read data is only meaningful for reads launched from IDLE.
  assign q    = rd_sel_q ? arr_rdata : (zero_q ? '0 : CLEAR_VALUE);
  assign busy = busy_q;

endmodule
